vuop_issue_queue: RTL and testbench
===================================

# vuop_issue_queue

Buffers per-register vector micro-ops produced by the LMUL grouping selector and issues them in order to the vector register-file read / ALU stage. Holds a RAW/WAW scoreboard over the 32 vector registers so a micro-op never reads or overwrites a register with an outstanding ALU writeback. Back-pressures the grouping selector and raises a fetch stall for IF1/IF2 when nearly full.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- REG_AW, 5: vector register address width; scoreboard has 2^REG_AW bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  grouping selector presents a micro-op.
- in_ready  out  1  queue accepts; = (count < DEPTH).
- in_raA, in_raB, in_rdest  in  REG_AW each  register indices already offset by the grouping selector.
- in_we  in  1  micro-op writes in_rdest.
- in_last  in  1  final micro-op of an LMUL group.
- out_valid  out  1  head micro-op issuable (non-empty, no hazard, no flush).
- out_ready  in  1  ALU stage accepts.
- out_raA, out_raB, out_rdest  out  REG_AW each  head fields.
- out_we, out_last  out  1 each  head fields.
- wb_valid  in  1  ALU writeback completes.
- wb_rdest  in  REG_AW  register being written back.
- flush  in  1  discard all queued micro-ops.
- fetch_stall  out  1  = (count ≥ DEPTH-1); stalls IF1/IF2.
- count  out  clog2(DEPTH)+1  occupancy.

## Operation
- Push on in_valid & in_ready; pop on out_valid & out_ready. Strict FIFO order, no reordering.
- Hazard at head: busy[out_raA] | busy[out_raB] | (busy[out_rdest] & out_we). Hazard forces out_valid=0; head stays.
- Scoreboard: busy[out_rdest] set on pop when out_we. busy[wb_rdest] cleared on wb_valid.
- Same-cycle set and clear of the same index: set wins (new write pending).
- No writeback bypass: hazard check uses registered busy; a register cleared this cycle is issuable next cycle.
- Because WAW blocks issue, at most one outstanding write per register; wb_valid to a non-busy register is ignored (no error).
- Simultaneous push and pop when count==DEPTH impossible (in_ready=0); when count==0 a push is not visible at the head until next cycle (no fall-through).
- flush: next cycle count=0, pointers reset, out_valid=0; push in flush cycle is dropped; pop in flush cycle still sets scoreboard. busy bits are NOT cleared by flush (in-flight ops still write back).
- Pointers wrap modulo DEPTH; count separate so full/empty unambiguous.

## Timing
- Reset values: count=0, pointers=0, all busy=0, out_valid=0, in_ready=1, fetch_stall=0; out_* data fields 0.
- Latency: push at edge N → earliest issue in cycle N+1 (out_valid high after edge N).
- Throughput: one push and one pop per cycle sustained when hazard-free.
- Dependent op (raA == previous rdest): issues the cycle after wb_valid for that register is sampled.
- in_ready, out_valid, fetch_stall depend only on registered state plus out_ready-independent logic; out_valid must not depend on out_ready.
- rst mid-operation: all entries and scoreboard cleared at next edge, regardless of inputs.

## Structure
- Shared vector package: REG_AW, VREG_COUNT, micro-op struct/field widths (raA, raB, rdest, we, last), shared with the grouping selector and ALU stage.
- One natural sub-module: vuop_scoreboard (busy vector, set/clear ports, three read ports).
- Queue storage and pointers inline in the top module.

## Test plan
- Reset then push 4 independent ops (rdest 1,2,3,4, sources 10..17), out_ready=1 → issued in order one per cycle from cycle 1; count returns 0; fetch_stall never asserted with continuous drain.
- out_ready=0, push 4 ops → count=4, in_ready=0, fetch_stall=1 from count=3; fifth push held; release out_ready → drains in order.
- Issue op rdest=v8 we=1, then op raA=v8 → second held out_valid=0; wb_valid wb_rdest=8 at cycle k → second issues at cycle k+1.
- WAW: two ops rdest=v5 we=1 → second blocked until wb v5; same cycle wb v5 and new issue with rdest=v5 → busy[5] stays 1.
- LMUL=4 group: rdest 4..7, last on 4th; then op raB=6 → blocks until wb_rdest=6 only, unaffected by wb for 4,5,7.
- Queue with 3 entries, busy[3]=1, assert flush → count=0, out_valid=0 next cycle, busy[3] still 1; rst → busy all 0.

Source files
------------

// File: rtl/vuop_issue_queue_pkg.sv
// Shared vector micro-op types used by the grouping selector, issue queue and ALU stage.
// Register indices arriving here already carry the LMUL group offset.
package vuop_issue_queue_pkg;

    localparam int REG_AW     = 5;
    localparam int VREG_COUNT = 1 << REG_AW;

    typedef logic [REG_AW-1:0] vreg_t;

    typedef struct packed {
        vreg_t raA;
        vreg_t raB;
        vreg_t rdest;
        logic  we;
        logic  last;
    } vuop_t;

endpackage

// File: rtl/vuop_issue_queue_if.sv
// Valid/ready micro-op channel; the master drives valid and uop, the slave returns ready.
// Used on both the enqueue and the issue side of the queue.
interface vuop_issue_queue_if;
    import vuop_issue_queue_pkg::*;

    logic  valid;
    logic  ready;
    vuop_t uop;

    modport master (output valid, output uop, input ready);
    modport slave  (input valid, input uop, output ready);
endinterface

// File: rtl/vuop_scoreboard.sv
// Busy bit per vector register: set when a writing op issues, cleared on ALU writeback.
// Reads see registered state only; a same-cycle set beats a clear of the same index.
module vuop_scoreboard
    import vuop_issue_queue_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  set_i,
    input  vreg_t set_idx_i,
    input  logic  clr_i,
    input  vreg_t clr_idx_i,
    input  vreg_t rd_a_idx_i,
    input  vreg_t rd_b_idx_i,
    input  vreg_t rd_d_idx_i,
    output logic  rd_a_busy_o,
    output logic  rd_b_busy_o,
    output logic  rd_d_busy_o
);

    logic [VREG_COUNT-1:0] busy_q;
    logic [VREG_COUNT-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rd_a_busy_o = busy_q[rd_a_idx_i];
    assign rd_b_busy_o = busy_q[rd_b_idx_i];
    assign rd_d_busy_o = busy_q[rd_d_idx_i];

endmodule

// File: rtl/vuop_issue_queue.sv
// In-order micro-op queue with RAW/WAW hold at the head; push visible at head one cycle later.
// in_ready drops when full, fetch_stall rises one entry early; out_valid ignores out_ready.
module vuop_issue_queue
    import vuop_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    vuop_issue_queue_if.slave         in_if,
    vuop_issue_queue_if.master        out_if,
    input  logic                      wb_valid,
    input  vreg_t                     wb_rdest,
    input  logic                      flush,
    output logic                      fetch_stall,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    vuop_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    vuop_t head;
    logic  busy_a, busy_b, busy_d;
    logic  hazard, push, pop;

    assign head   = mem_q[rd_ptr_q];
    assign hazard = busy_a | busy_b | (busy_d & head.we);

    assign in_if.ready  = (count_q < CW'(DEPTH));
    assign out_if.valid = (count_q != '0) && !hazard;
    assign out_if.uop   = head;
    assign fetch_stall  = (count_q >= CW'(DEPTH - 1));
    assign count        = count_q;

    assign push = in_if.valid & in_if.ready;
    assign pop  = out_if.valid & out_if.ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= in_if.uop;
        end
    end

    // A pop during flush still marks its destination: that op really reaches the ALU.
    vuop_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_i       (pop & head.we),
        .set_idx_i   (head.rdest),
        .clr_i       (wb_valid),
        .clr_idx_i   (wb_rdest),
        .rd_a_idx_i  (head.raA),
        .rd_b_idx_i  (head.raB),
        .rd_d_idx_i  (head.rdest),
        .rd_a_busy_o (busy_a),
        .rd_b_busy_o (busy_b),
        .rd_d_busy_o (busy_d)
    );

endmodule

// File: tb/tb_vuop_issue_queue.sv
// Directed bench for the vector micro-op issue queue: ordering, full/stall, RAW/WAW, LMUL groups, flush.
module tb_vuop_issue_queue;
    import vuop_issue_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    vreg_t      wb_rdest;
    logic       flush;
    logic       fetch_stall;
    logic [2:0] count;
    int         passed = 0;
    int         total  = 0;

    vuop_issue_queue_if in_if ();
    vuop_issue_queue_if out_if ();

    vuop_issue_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (in_if),
        .out_if      (out_if),
        .wb_valid    (wb_valid),
        .wb_rdest    (wb_rdest),
        .flush       (flush),
        .fetch_stall (fetch_stall),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running exp finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input int ra, input int rb, input int rd,
                          input logic we, input logic last);
        in_if.valid     = v;
        in_if.uop.raA   = vreg_t'(ra);
        in_if.uop.raB   = vreg_t'(rb);
        in_if.uop.rdest = vreg_t'(rd);
        in_if.uop.we    = we;
        in_if.uop.last  = last;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b0);
        out_if.ready = 1'b0;
        wb_valid = 1'b0;
        wb_rdest = '0;
        flush = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 7, 8, 9, 1'b1, 1'b1);
        out_if.ready = 1'b1;
        wb_valid = 1'b0;
        wb_rdest = '0;
        flush = 1'b0;
        step();
        rst = 1'b0;
        in_if.valid = 1'b0;
        #1;
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (out_if.valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_if.valid); else passed++;
        total++; if (in_if.ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_if.ready); else passed++;
        total++; if (fetch_stall !== 1'b0) $display("FAIL reset_fetch_stall got %b exp 0", fetch_stall); else passed++;
        total++; if (out_if.uop !== '0) $display("FAIL reset_out_uop got %h exp 0", out_if.uop); else passed++;
    endtask

    task automatic test_stream();
        do_reset();
        out_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_in(1'b1, 10 + 2*i, 11 + 2*i, i + 1, 1'b1, 1'b0);
            else       in_if.valid = 1'b0;
            #1;
            if (i == 0) begin
                total++; if (out_if.valid !== 1'b0) $display("FAIL stream_no_fallthrough got %b exp 0", out_if.valid); else passed++;
            end else begin
                total++; if (out_if.valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", i, out_if.valid); else passed++;
                total++; if (out_if.uop.rdest !== vreg_t'(i)) $display("FAIL stream_rdest[%0d] got %0d exp %0d", i, out_if.uop.rdest, i); else passed++;
                total++; if (out_if.uop.raA !== vreg_t'(8 + 2*i)) $display("FAIL stream_raA[%0d] got %0d exp %0d", i, out_if.uop.raA, 8 + 2*i); else passed++;
            end
            total++; if (fetch_stall !== 1'b0) $display("FAIL stream_fetch_stall[%0d] got %b exp 0", i, fetch_stall); else passed++;
            step();
        end
        total++; if (count !== 3'd0) $display("FAIL stream_final_count got %0d exp 0", count); else passed++;
        total++; if (out_if.valid !== 1'b0) $display("FAIL stream_final_valid got %b exp 0", out_if.valid); else passed++;
    endtask

    task automatic test_full();
        int exp_rd [5] = '{1, 2, 3, 4, 9};
        do_reset();
        out_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 10 + 2*i, 11 + 2*i, i + 1, 1'b1, 1'b0);
            step();
            total++; if (count !== 3'(i + 1)) $display("FAIL full_count[%0d] got %0d exp %0d", i, count, i + 1); else passed++;
            total++; if (fetch_stall !== (i >= 2)) $display("FAIL full_fetch_stall[%0d] got %b exp %b", i, fetch_stall, (i >= 2)); else passed++;
            total++; if (in_if.ready !== (i < 3)) $display("FAIL full_in_ready[%0d] got %b exp %b", i, in_if.ready, (i < 3)); else passed++;
        end
        set_in(1'b1, 20, 21, 9, 1'b1, 1'b0);
        step();
        total++; if (count !== 3'd4) $display("FAIL full_fifth_held got %0d exp 4", count); else passed++;
        out_if.ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (j == 2) in_if.valid = 1'b0;
            #1;
            if (j == 0) begin
                total++; if (in_if.ready !== 1'b0) $display("FAIL full_ready_at_release got %b exp 0", in_if.ready); else passed++;
            end
            total++; if (out_if.valid !== 1'b1) $display("FAIL drain_valid[%0d] got %b exp 1", j, out_if.valid); else passed++;
            total++; if (out_if.uop.rdest !== vreg_t'(exp_rd[j])) $display("FAIL drain_rdest[%0d] got %0d exp %0d", j, out_if.uop.rdest, exp_rd[j]); else passed++;
            step();
        end
        total++; if (count !== 3'd0) $display("FAIL drain_count got %0d exp 0", count); else passed++;
    endtask

    task automatic test_raw();
        do_reset();
        out_if.ready = 1'b1;
        set_in(1'b1, 20, 21, 8, 1'b1, 1'b0);
        step();
        set_in(1'b1, 8, 22, 9, 1'b1, 1'b0);
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL raw_producer_valid got %b exp 1", out_if.valid); else passed++;
        step();
        in_if.valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (out_if.valid !== 1'b0) $display("FAIL raw_held[%0d] got %b exp 0", k, out_if.valid); else passed++;
            step();
        end
        wb_valid = 1'b1;
        wb_rdest = 5'd8;
        #1;
        total++; if (out_if.valid !== 1'b0) $display("FAIL raw_no_bypass got %b exp 0", out_if.valid); else passed++;
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL raw_issue_after_wb got %b exp 1", out_if.valid); else passed++;
        total++; if (out_if.uop.rdest !== 5'd9) $display("FAIL raw_issue_rdest got %0d exp 9", out_if.uop.rdest); else passed++;
        step();
        total++; if (count !== 3'd0) $display("FAIL raw_final_count got %0d exp 0", count); else passed++;
    endtask

    task automatic test_waw();
        do_reset();
        out_if.ready = 1'b1;
        set_in(1'b1, 1, 2, 5, 1'b1, 1'b0);
        step();
        set_in(1'b1, 3, 4, 5, 1'b1, 1'b0);
        step();
        set_in(1'b1, 5, 7, 6, 1'b1, 1'b0);
        #1;
        total++; if (out_if.valid !== 1'b0) $display("FAIL waw_second_blocked got %b exp 0", out_if.valid); else passed++;
        step();
        in_if.valid = 1'b0;
        wb_valid = 1'b1;
        wb_rdest = 5'd5;
        #1;
        total++; if (out_if.valid !== 1'b0) $display("FAIL waw_blocked_during_wb got %b exp 0", out_if.valid); else passed++;
        step();
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL waw_second_issues got %b exp 1", out_if.valid); else passed++;
        total++; if (out_if.uop.raA !== 5'd3) $display("FAIL waw_second_raA got %0d exp 3", out_if.uop.raA); else passed++;
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b0) $display("FAIL waw_set_wins got %b exp 0", out_if.valid); else passed++;
        step();
        wb_valid = 1'b1;
        wb_rdest = 5'd5;
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL waw_reader_issues got %b exp 1", out_if.valid); else passed++;
        total++; if (out_if.uop.rdest !== 5'd6) $display("FAIL waw_reader_rdest got %0d exp 6", out_if.uop.rdest); else passed++;
        step();
    endtask

    task automatic test_lmul();
        int wb_seq [4] = '{4, 5, 7, 6};
        do_reset();
        out_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_in(1'b1, 20 + 2*i, 21 + 2*i, 4 + i, 1'b1, i == 3);
            else       set_in(1'b1, 28, 6, 12, 1'b1, 1'b1);
            #1;
            if (i > 0) begin
                total++; if (out_if.uop.rdest !== vreg_t'(3 + i)) $display("FAIL lmul_rdest[%0d] got %0d exp %0d", i, out_if.uop.rdest, 3 + i); else passed++;
                total++; if (out_if.uop.last !== (i == 4)) $display("FAIL lmul_last[%0d] got %b exp %b", i, out_if.uop.last, (i == 4)); else passed++;
            end
            step();
        end
        in_if.valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wb_valid = 1'b1;
            wb_rdest = vreg_t'(wb_seq[k]);
            #1;
            total++; if (out_if.valid !== 1'b0) $display("FAIL lmul_blocked_wb%0d got %b exp 0", wb_seq[k], out_if.valid); else passed++;
            step();
        end
        wb_valid = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL lmul_issue_after_wb6 got %b exp 1", out_if.valid); else passed++;
        total++; if (out_if.uop.rdest !== 5'd12) $display("FAIL lmul_consumer_rdest got %0d exp 12", out_if.uop.rdest); else passed++;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        out_if.ready = 1'b1;
        set_in(1'b1, 10, 11, 3, 1'b1, 1'b0);
        step();
        in_if.valid = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL flush_setup_issue got %b exp 1", out_if.valid); else passed++;
        step();
        out_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 12 + i, 20 + i, 13 + i, 1'b1, 1'b0);
            step();
        end
        in_if.valid = 1'b0;
        total++; if (count !== 3'd3) $display("FAIL flush_pre_count got %0d exp 3", count); else passed++;
        total++; if (fetch_stall !== 1'b1) $display("FAIL flush_pre_stall got %b exp 1", fetch_stall); else passed++;
        flush = 1'b1;
        set_in(1'b1, 14, 15, 16, 1'b1, 1'b0);
        step();
        flush = 1'b0;
        in_if.valid = 1'b0;
        #1;
        total++; if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count); else passed++;
        total++; if (out_if.valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", out_if.valid); else passed++;
        total++; if (fetch_stall !== 1'b0) $display("FAIL flush_fetch_stall got %b exp 0", fetch_stall); else passed++;
        out_if.ready = 1'b1;
        set_in(1'b1, 3, 4, 17, 1'b1, 1'b0);
        step();
        in_if.valid = 1'b0;
        #1;
        total++; if (out_if.uop.raA !== 5'd3) $display("FAIL flush_ptr_reset_raA got %0d exp 3", out_if.uop.raA); else passed++;
        total++; if (out_if.valid !== 1'b0) $display("FAIL flush_busy_kept got %b exp 0", out_if.valid); else passed++;
        step();
        total++; if (count !== 3'd1) $display("FAIL flush_held_count got %0d exp 1", count); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
        total++; if (out_if.valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_if.valid); else passed++;
        set_in(1'b1, 3, 4, 17, 1'b1, 1'b0);
        step();
        in_if.valid = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b1) $display("FAIL rst_busy_cleared got %b exp 1", out_if.valid); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_raw();
        test_waw();
        test_lmul();
        test_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
